merge2_arb: RTL and testbench

MERGE2_ARB -- requirements
Module: merge2_arb

---
 rtl/merge2_arb_pkg.sv | 24 ++
 rtl/merge2_arb_flit_buf1.sv | 47 ++++
 rtl/merge2_arb.sv | 118 +++++++++++
 tb/tb_merge2_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/merge2_arb_pkg.sv
// Shared definitions for the two-input round-robin flit merger.
package merge2_arb_pkg;

    // Flit layout: [8:5] address, [4:0] payload
    localparam int unsigned FLIT_W  = 9;
    localparam int unsigned ADDR_HI = 8;
    localparam int unsigned ADDR_LO = 5;

    // Source-select encoding carried on out_sel
    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    // Output register control
    typedef enum logic {
        StEmpty = 1'b0,
        StHold  = 1'b1
    } out_state_e;

    // Extract the address field of a flit
    function automatic logic [ADDR_HI-ADDR_LO:0] flit_addr(input logic [FLIT_W-1:0] flit);
        return flit[ADDR_HI:ADDR_LO];
    endfunction

endpackage

// File: rtl/merge2_arb_flit_buf1.sv
// One-entry input buffer: holds a single flit plus a full flag.
// A drain and a new accept may happen on the same edge.
module flit_buf1 #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         drain,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Ready while empty or while the held flit leaves this cycle
    assign in_ready = ~full_q | drain;
    assign full     = full_q;
    assign data     = data_q;

    // Next-state: accept takes priority, since it also covers refill-on-drain
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // Buffer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/merge2_arb.sv
// Two-input round-robin merger: two one-entry input buffers feed a single
// output register; per-input saturating grant counters track deliveries.
module merge2_arb
    import merge2_arb_pkg::*;
#(
    parameter int unsigned W  = FLIT_W,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in0_data,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [W-1:0]  in1_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [W-1:0]  out_data,
    output logic          out_sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] gcnt0,
    output logic [CW-1:0] gcnt1
);

    logic         full0, full1;
    logic [W-1:0] buf0, buf1;
    logic         out_free, grant_any, winner, grant0, grant1, xfer;

    out_state_e    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [W-1:0]  data_q, data_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;

    flit_buf1 #(.W(W)) u_buf0 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in0_data),
        .in_valid (in0_valid),
        .in_ready (in0_ready),
        .drain    (grant0),
        .full     (full0),
        .data     (buf0)
    );

    flit_buf1 #(.W(W)) u_buf1 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in1_data),
        .in_valid (in1_valid),
        .in_ready (in1_ready),
        .drain    (grant1),
        .full     (full1),
        .data     (buf1)
    );

    assign out_valid = (state_q == StHold);
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign gcnt0     = gcnt0_q;
    assign gcnt1     = gcnt1_q;
    assign xfer      = out_valid & out_ready;

    // Round-robin arbitration whenever the output register can take a flit
    always_comb begin
        out_free  = (state_q == StEmpty) | out_ready;
        grant_any = out_free & (full0 | full1);
        winner    = (full0 & full1) ? ptr_q : full1;
        grant0    = grant_any & (winner == SEL_IN0);
        grant1    = grant_any & (winner == SEL_IN1);
    end

    // Output register control and next-state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (grant_any) begin
            data_d = winner ? buf1 : buf0;
            sel_d  = winner;
            ptr_d  = ~winner;
        end
        unique case (state_q)
            StEmpty: if (grant_any) state_d = StHold;
            StHold:  if (out_ready && !grant_any) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Saturating per-source delivery counters
    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (xfer && (sel_q == SEL_IN0) && (gcnt0_q != '1)) gcnt0_d = gcnt0_q + CW'(1);
        if (xfer && (sel_q == SEL_IN1) && (gcnt1_q != '1)) gcnt1_d = gcnt1_q + CW'(1);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

endmodule

// File: tb/tb_merge2_arb.sv
// Scoreboard bench for merge2_arb: accepted input flits are queued per source,
// a monitor pops and compares on every output transfer.
module tb_merge2_arb;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in0_data, in1_data;
    logic         in0_valid, in1_valid, out_ready;
    logic         in0_ready, in1_ready, out_sel, out_valid;
    logic [W-1:0] out_data;
    logic [7:0]   gcnt0, gcnt1;

    // Second instance with 2-bit counters, sharing all inputs
    logic         s_in0_ready, s_in1_ready, s_out_sel, s_out_valid;
    logic [W-1:0] s_out_data;
    logic [1:0]   s_gcnt0, s_gcnt1;

    int checks   = 0;
    int failures = 0;
    int ntx      = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] mon_exp;

    always #5 clk = ~clk;

    merge2_arb #(.W(W), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .gcnt0(gcnt0), .gcnt1(gcnt1)
    );

    merge2_arb #(.W(W), .CW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(s_in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(s_in1_ready),
        .out_data(s_out_data), .out_sel(s_out_sel), .out_valid(s_out_valid),
        .out_ready(out_ready), .gcnt0(s_gcnt0), .gcnt1(s_gcnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: inputs are stable from posedge+1 to the next posedge, so the
    // negedge sees exactly what the coming edge will sample.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (out_valid && out_ready) begin
                ntx++;
                if (out_sel == 1'b0) begin
                    if (q0.size() == 0) check("sb_spurious_src0", 32'd0, 32'd1);
                    else begin
                        mon_exp = q0.pop_front();
                        check("sb_data_src0", 32'(out_data), 32'(mon_exp));
                    end
                end else begin
                    if (q1.size() == 0) check("sb_spurious_src1", 32'd0, 32'd1);
                    else begin
                        mon_exp = q1.pop_front();
                        check("sb_data_src1", 32'(out_data), 32'(mon_exp));
                    end
                end
            end
            if (in0_valid && in0_ready) q0.push_back(in0_data);
            if (in1_valid && in1_ready) q1.push_back(in1_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] seq0 [3];
        int idx;
        int tx0;
        logic rdy;
        seq0 = '{9'h0A1, 9'h0A2, 9'h0A3};

        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = '0; in1_data = '0;
        in0_valid = 1'b1; in1_valid = 1'b1;   // offered during reset: must not transfer
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_gcnt0", 32'(gcnt0), 32'd0);
        check("rst_gcnt1", 32'(gcnt1), 32'd0);
        check("rst_in0_ready", 32'(in0_ready), 32'd1);
        check("rst_in1_ready", 32'(in1_ready), 32'd1);
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Single flit from input 0
        in0_data = 9'h0A5; in0_valid = 1'b1; out_ready = 1'b1;
        tick();
        in0_valid = 1'b0;
        check("single_lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", 32'(out_data), 32'h0A5);
        check("single_out_sel", 32'(out_sel), 32'd0);
        tick();
        check("single_gcnt0", 32'(gcnt0), 32'd1);
        check("single_drained", 32'(out_valid), 32'd0);

        // Both inputs streaming: alternating 0,1,0,1 at full rate
        do_reset();
        in0_data = 9'h111; in1_data = 9'h122;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_sel", 32'(out_sel), 32'(i % 2));
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        repeat (5) tick();
        check("rr_q0_empty", 32'(q0.size()), 32'd0);
        check("rr_q1_empty", 32'(q1.size()), 32'd0);
        check("rr_gcnt0", 32'(gcnt0), 32'd4);
        check("rr_gcnt1", 32'(gcnt1), 32'd4);

        // Output stall with both inputs valid
        do_reset();
        tx0 = ntx;
        in0_data = 9'h031; in1_data = 9'h042;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'h031);
            check("stall_out_sel", 32'(out_sel), 32'd0);
            check("stall_in0_ready", 32'(in0_ready), 32'd0);
            check("stall_in1_ready", 32'(in1_ready), 32'd0);
            tick();
        end
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        check("stall_delivered", 32'(ntx - tx0), 32'd3);
        check("stall_q0_empty", 32'(q0.size()), 32'd0);
        check("stall_q1_empty", 32'(q1.size()), 32'd0);
        check("stall_idle", 32'(out_valid), 32'd0);

        // Drain and refill of input 0 on the same edge, order preserved
        do_reset();
        tx0 = ntx;
        idx = 0;
        in0_data = seq0[0]; in0_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 3; i++) begin
            rdy = in0_ready;
            tick();
            if (rdy) begin
                idx++;
                if (idx == 1) check("refill_ready_on_grant", 32'(in0_ready), 32'd1);
                if (idx < 3) in0_data = seq0[idx];
                else in0_valid = 1'b0;
            end
        end
        check("refill_accepts", 32'(idx), 32'd3);
        repeat (4) tick();
        check("refill_delivered", 32'(ntx - tx0), 32'd3);
        check("refill_q0_empty", 32'(q0.size()), 32'd0);

        // Counter saturation: five flits from input 1
        do_reset();
        idx = 0;
        in1_data = 9'h1E0; in1_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 30 && idx < 5; i++) begin
            rdy = in1_ready;
            tick();
            if (rdy) begin
                idx++;
                if (idx < 5) in1_data = 9'(9'h1E0 + idx);
                else in1_valid = 1'b0;
            end
        end
        check("sat_accepts", 32'(idx), 32'd5);
        repeat (4) tick();
        check("sat_gcnt1_cw8", 32'(gcnt1), 32'd5);
        check("sat_gcnt1_cw2", 32'(s_gcnt1), 32'd3);
        check("sat_gcnt0_cw2", 32'(s_gcnt0), 32'd0);
        check("sat_gcnt0_cw8", 32'(gcnt0), 32'd0);

        // Reset while holding a flit with both buffers full
        in0_data = 9'h0B1; in1_data = 9'h1C2;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
        repeat (3) tick();
        check("midrst_pre_valid", 32'(out_valid), 32'd1);
        check("midrst_pre_full", 32'(in0_ready | in1_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_sel", 32'(out_sel), 32'd0);
        check("midrst_gcnt1", 32'(gcnt1), 32'd0);
        check("midrst_in0_ready", 32'(in0_ready), 32'd1);
        check("midrst_in1_ready", 32'(in1_ready), 32'd1);
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        tx0 = ntx;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_no_xfer", 32'(ntx - tx0), 32'd0);
        check("midrst_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
